// File: rtl/pool_window_gen_pkg.sv
// Shared defaults and helpers for the pooling window generator.
// Default sample width, window edge and stride, plus the window element offset.
package pool_window_gen_pkg;

   localparam int unsigned IF_BW        = 32;
   localparam int unsigned POOL_IN_SIZE = 2;
   localparam int unsigned POOL_STRIDE  = 2;

   // Bit offset of window element (r,c) in a packed K*K window of PW-bit pixels
   function automatic int unsigned win_elem_idx(input int unsigned r,
                                                input int unsigned c,
                                                input int unsigned k,
                                                input int unsigned pw);
      return (r * k + c) * pw;
   endfunction

endpackage

// File: rtl/pool_window_gen_line_delay.sv
// Single-line delay: emits the word written DEPTH enabled cycles earlier.
// Storage has no reset; downstream gating masks stale contents.
module pool_window_gen_line_delay #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned W     = 32
) (
   input  logic         clk,
   input  logic         i_en,
   input  logic [W-1:0] i_din,
   output logic [W-1:0] o_dout
);

   logic [DEPTH*W-1:0] r_sr;

   always_ff @(posedge clk) begin
      if (i_en) begin
         r_sr <= {r_sr[(DEPTH-1)*W-1:0], i_din};
      end
   end

   assign o_dout = r_sr[DEPTH*W-1 -: W];

endmodule

// File: rtl/pool_window_gen.sv
// Streaming KxK sliding-window generator with stride, raster-order input.
// Buffers K-1 lines and emits a registered packed window at each stride point.
module pool_window_gen
   import pool_window_gen_pkg::*;
#(
   parameter int unsigned IX     = 32,
   parameter int unsigned IY     = 32,
   parameter int unsigned K      = POOL_IN_SIZE,
   parameter int unsigned STRIDE = POOL_STRIDE,
   parameter int unsigned BW     = IF_BW,
   parameter int unsigned CH     = 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     i_soft_clr,
   input  logic                     i_in_valid,
   input  logic [CH*BW-1:0]         i_in_pixel,
   output logic                     o_window_valid,
   output logic [K*K*CH*BW-1:0]     o_window,
   output logic [$clog2(IX)-1:0]    o_win_x,
   output logic [$clog2(IY)-1:0]    o_win_y,
   output logic                     o_frame_done
);

   localparam int unsigned PW  = CH * BW;
   localparam int unsigned WW  = K * K * PW;
   localparam int unsigned XW  = $clog2(IX);
   localparam int unsigned YW  = $clog2(IY);
   localparam int unsigned PHW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

   logic [XW-1:0]  r_x;
   logic [YW-1:0]  r_y;
   logic [PHW-1:0] r_px;
   logic [PHW-1:0] r_py;
   logic [WW-1:0]  r_win;
   logic [WW-1:0]  r_window;
   logic [XW-1:0]  r_win_x;
   logic [YW-1:0]  r_win_y;
   logic           r_window_valid;
   logic           r_frame_done;

   logic           w_accept;
   logic           w_last_x;
   logic           w_last_y;
   logic           w_x_ok;
   logic           w_y_ok;
   logic           w_emit;
   logic [PHW-1:0] w_px_next;
   logic [PHW-1:0] w_py_next;
   logic [WW-1:0]  w_win_next;
   logic [K*PW-1:0] w_col;
   logic [PW-1:0]  w_line_out [K-1];

   // A clear in the same cycle drops the pixel
   assign w_accept = i_in_valid & ~i_soft_clr;

   genvar gj, gr, gc;
   for (gj = 0; gj < K - 1; gj++) begin : g_line
      logic [PW-1:0] w_din;
      if (gj == 0) begin : g_first
         assign w_din = i_in_pixel;
      end else begin : g_chain
         assign w_din = w_line_out[gj-1];
      end
      pool_window_gen_line_delay #(
         .DEPTH (IX),
         .W     (PW)
      ) u_line (
         .clk    (clk),
         .i_en   (w_accept),
         .i_din  (w_din),
         .o_dout (w_line_out[gj])
      );
   end

   // Incoming column: oldest line at row 0, live pixel at row K-1
   for (gr = 0; gr < K; gr++) begin : g_col
      if (gr == K - 1) begin : g_live
         assign w_col[gr*PW +: PW] = i_in_pixel;
      end else begin : g_buf
         assign w_col[gr*PW +: PW] = w_line_out[K-2-gr];
      end
   end

   for (gr = 0; gr < K; gr++) begin : g_row
      for (gc = 0; gc < K; gc++) begin : g_elem
         if (gc < K - 1) begin : g_shift
            assign w_win_next[win_elem_idx(gr, gc, K, PW) +: PW] =
               r_win[win_elem_idx(gr, gc + 1, K, PW) +: PW];
         end else begin : g_new
            assign w_win_next[win_elem_idx(gr, gc, K, PW) +: PW] = w_col[gr*PW +: PW];
         end
      end
   end

   assign w_last_x  = (r_x == XW'(IX - 1));
   assign w_last_y  = (r_y == YW'(IY - 1));
   assign w_x_ok    = (r_x >= XW'(K - 1));
   assign w_y_ok    = (r_y >= YW'(K - 1));
   assign w_px_next = (r_px == PHW'(STRIDE - 1)) ? '0 : r_px + PHW'(1);
   assign w_py_next = (r_py == PHW'(STRIDE - 1)) ? '0 : r_py + PHW'(1);
   assign w_emit    = w_accept & w_x_ok & w_y_ok & (r_px == '0) & (r_py == '0);

   // Position counters, stride phases and registered window outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_x            <= '0;
         r_y            <= '0;
         r_px           <= '0;
         r_py           <= '0;
         r_win          <= '0;
         r_window       <= '0;
         r_win_x        <= '0;
         r_win_y        <= '0;
         r_window_valid <= 1'b0;
         r_frame_done   <= 1'b0;
      end else if (i_soft_clr) begin
         r_x            <= '0;
         r_y            <= '0;
         r_px           <= '0;
         r_py           <= '0;
         r_window_valid <= 1'b0;
         r_frame_done   <= 1'b0;
      end else begin
         r_window_valid <= 1'b0;
         r_frame_done   <= 1'b0;
         if (w_accept) begin
            r_win        <= w_win_next;
            r_frame_done <= w_last_x & w_last_y;
            if (w_last_x) begin
               r_x  <= '0;
               r_px <= '0;
               if (w_last_y) begin
                  r_y  <= '0;
                  r_py <= '0;
               end else begin
                  r_y <= r_y + YW'(1);
                  if (w_y_ok) begin
                     r_py <= w_py_next;
                  end
               end
            end else begin
               r_x <= r_x + XW'(1);
               if (w_x_ok) begin
                  r_px <= w_px_next;
               end
            end
            if (w_emit) begin
               r_window_valid <= 1'b1;
               r_window       <= w_win_next;
               r_win_x        <= r_x - XW'(K - 1);
               r_win_y        <= r_y - YW'(K - 1);
            end
         end
      end
   end

   assign o_window_valid = r_window_valid;
   assign o_window       = r_window;
   assign o_win_x        = r_win_x;
   assign o_win_y        = r_win_y;
   assign o_frame_done   = r_frame_done;

endmodule

// File: tb/tb_pool_window_gen.sv
// Directed bench for pool_window_gen: three configurations driven from one sequence.
// Expected windows are built from the ramp pixel values and window coordinates.
module tb_pool_window_gen;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Config A: 4x4, K=2, STRIDE=2, 32-bit single channel
   logic         a_clr, a_vld, a_wv, a_fd;
   logic [31:0]  a_pix;
   logic [127:0] a_win;
   logic [1:0]   a_wx, a_wy;

   // Config B: 5x5, K=3, STRIDE=1
   logic         b_clr, b_vld, b_wv, b_fd;
   logic [31:0]  b_pix;
   logic [287:0] b_win;
   logic [2:0]   b_wx, b_wy;

   // Config C: 3x3, K=2, STRIDE=1, two 8-bit channels
   logic         c_clr, c_vld, c_wv, c_fd;
   logic [15:0]  c_pix;
   logic [63:0]  c_win;
   logic [1:0]   c_wx, c_wy;

   pool_window_gen #(.IX(4), .IY(4), .K(2), .STRIDE(2), .BW(32), .CH(1)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .i_soft_clr(a_clr), .i_in_valid(a_vld),
      .i_in_pixel(a_pix), .o_window_valid(a_wv), .o_window(a_win),
      .o_win_x(a_wx), .o_win_y(a_wy), .o_frame_done(a_fd));

   pool_window_gen #(.IX(5), .IY(5), .K(3), .STRIDE(1), .BW(32), .CH(1)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .i_soft_clr(b_clr), .i_in_valid(b_vld),
      .i_in_pixel(b_pix), .o_window_valid(b_wv), .o_window(b_win),
      .o_win_x(b_wx), .o_win_y(b_wy), .o_frame_done(b_fd));

   pool_window_gen #(.IX(3), .IY(3), .K(2), .STRIDE(1), .BW(8), .CH(2)) u_dut_c (
      .clk(clk), .reset_n(reset_n), .i_soft_clr(c_clr), .i_in_valid(c_vld),
      .i_in_pixel(c_pix), .o_window_valid(c_wv), .o_window(c_win),
      .o_win_x(c_wx), .o_win_y(c_wy), .o_frame_done(c_fd));

   typedef struct {
      logic [127:0] w;
      logic [1:0]   x;
      logic [1:0]   y;
      logic         fd;
   } exp_a_t;

   exp_a_t       a_q[$];
   logic [127:0] a_last_w;
   logic [1:0]   a_last_x, a_last_y;
   int           b_n, c_n;
   logic [287:0] b_last_w, b_ref;
   logic [63:0]  c_last_w;
   logic [15:0]  c_elem;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_a(input int base, input int tl, input int x, input int y, input logic fd);
      exp_a_t e;
      e.w  = {32'(base + tl + 5), 32'(base + tl + 4), 32'(base + tl + 1), 32'(base + tl)};
      e.x  = 2'(x);
      e.y  = 2'(y);
      e.fd = fd;
      a_q.push_back(e);
   endtask

   task automatic push_frame_a(input int base);
      push_a(base, 0,  0, 0, 1'b0);
      push_a(base, 2,  2, 0, 1'b0);
      push_a(base, 8,  0, 2, 1'b0);
      push_a(base, 10, 2, 2, 1'b1);
   endtask

   // One clock of config A, then check strobe contents or held outputs
   task automatic step_a(input logic v, input logic [31:0] p, input logic clr);
      exp_a_t e;
      a_vld = v;
      a_pix = p;
      a_clr = clr;
      @(posedge clk);
      #1;
      if (a_wv === 1'b1) begin
         chk("a_strobe_expected", 512'(a_q.size() != 0), 512'(1));
         if (a_q.size() != 0) begin
            e = a_q.pop_front();
            chk("a_window", a_win, e.w);
            chk("a_win_x", a_wx, e.x);
            chk("a_win_y", a_wy, e.y);
            chk("a_frame_done_on_strobe", a_fd, e.fd);
         end
         a_last_w = a_win;
         a_last_x = a_wx;
         a_last_y = a_wy;
      end else begin
         chk("a_valid_idle", a_wv, 1'b0);
         chk("a_hold_window", a_win, a_last_w);
         chk("a_hold_xy", {a_wx, a_wy}, {a_last_x, a_last_y});
         chk("a_frame_done_idle", a_fd, 1'b0);
      end
   endtask

   function automatic logic [287:0] exp_b(input int wx, input int wy);
      logic [287:0] w;
      w = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            w[(r*3+c)*32 +: 32] = 32'((wy + r) * 5 + wx + c);
      return w;
   endfunction

   function automatic logic [63:0] exp_c(input int wx, input int wy);
      logic [63:0] w;
      int p;
      w = '0;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++) begin
            p = (wy + r) * 3 + wx + c;
            w[(r*2+c)*16 +: 16] = {8'(p + 64), 8'(p)};
         end
      return w;
   endfunction

   task automatic step_b(input logic v, input int p);
      b_vld = v;
      b_pix = 32'(p);
      @(posedge clk);
      #1;
      if (b_wv === 1'b1) begin
         chk("b_window", b_win, exp_b(b_n % 3, b_n / 3));
         chk("b_win_xy", {b_wx, b_wy}, {3'(b_n % 3), 3'(b_n / 3)});
         chk("b_frame_done", b_fd, 512'(b_n == 8));
         b_last_w = b_win;
         b_n++;
      end else begin
         chk("b_valid_idle", b_wv, 1'b0);
         chk("b_frame_done_idle", b_fd, 1'b0);
      end
   endtask

   task automatic step_c(input logic v, input int p);
      c_vld = v;
      c_pix = {8'(p + 64), 8'(p)};
      @(posedge clk);
      #1;
      if (c_wv === 1'b1) begin
         chk("c_window", c_win, exp_c(c_n % 2, c_n / 2));
         chk("c_win_xy", {c_wx, c_wy}, {2'(c_n % 2), 2'(c_n / 2)});
         chk("c_frame_done", c_fd, 512'(c_n == 3));
         c_last_w = c_win;
         c_n++;
      end else begin
         chk("c_valid_idle", c_wv, 1'b0);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_a_valid", a_wv, 1'b0);
      chk("rst_a_window", a_win, '0);
      chk("rst_a_xy", {a_wx, a_wy}, '0);
      chk("rst_a_frame_done", a_fd, 1'b0);
      chk("rst_b_outputs", {b_wv, b_win, b_wx, b_wy, b_fd}, '0);
      chk("rst_c_outputs", {c_wv, c_win, c_wx, c_wy, c_fd}, '0);
   endtask

   initial begin
      int lst[9];
      reset_n = 1'b0;
      {a_clr, a_vld, a_pix} = '0;
      {b_clr, b_vld, b_pix} = '0;
      {c_clr, c_vld, c_pix} = '0;
      a_last_w = '0;
      a_last_x = '0;
      a_last_y = '0;
      b_n = 0;
      c_n = 0;
      #2;
      chk_reset_outputs();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // A: clean ramp 0..15, first strobe right after pixel 5
      push_frame_a(0);
      for (int i = 0; i < 16; i++) begin
         step_a(1'b1, 32'(i), 1'b0);
         if (i == 5) chk("a_first_strobe_latency", a_wv, 1'b1);
      end
      step_a(1'b0, 32'hdead_beef, 1'b0);
      chk("a_frame1_all_strobes", 512'(a_q.size()), 512'(0));

      // A: same ramp with random idle gaps carrying junk pixels
      push_frame_a(0);
      for (int i = 0; i < 16; i++) begin
         repeat ($urandom_range(0, 2)) step_a(1'b0, $urandom, 1'b0);
         step_a(1'b1, 32'(i), 1'b0);
      end
      repeat (2) step_a(1'b0, $urandom, 1'b0);
      chk("a_gaps_all_strobes", 512'(a_q.size()), 512'(0));

      // A: two frames back to back, second ramp 100..115
      push_frame_a(0);
      push_frame_a(100);
      for (int i = 0; i < 16; i++) step_a(1'b1, 32'(i), 1'b0);
      for (int i = 0; i < 16; i++) step_a(1'b1, 32'(100 + i), 1'b0);
      step_a(1'b0, '0, 1'b0);
      chk("a_two_frames_all_strobes", 512'(a_q.size()), 512'(0));

      // A: soft clear after pixel 9 with a colliding pixel that must be dropped
      push_a(0, 0, 0, 0, 1'b0);
      push_a(0, 2, 2, 0, 1'b0);
      for (int i = 0; i < 10; i++) step_a(1'b1, 32'(i), 1'b0);
      step_a(1'b1, 32'd99, 1'b1);
      chk("a_clr_valid_low", a_wv, 1'b0);
      push_frame_a(0);
      for (int i = 0; i < 16; i++) step_a(1'b1, 32'(i), 1'b0);
      step_a(1'b0, '0, 1'b0);
      chk("a_after_clr_all_strobes", 512'(a_q.size()), 512'(0));

      // A: asynchronous reset mid-frame after pixel 9
      push_a(0, 0, 0, 0, 1'b0);
      push_a(0, 2, 2, 0, 1'b0);
      for (int i = 0; i < 10; i++) step_a(1'b1, 32'(i), 1'b0);
      a_vld = 1'b0;
      reset_n = 1'b0;
      #2;
      chk_reset_outputs();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      a_last_w = '0;
      a_last_x = '0;
      a_last_y = '0;
      push_frame_a(0);
      for (int i = 0; i < 16; i++) step_a(1'b1, 32'(i), 1'b0);
      step_a(1'b0, '0, 1'b0);
      chk("a_after_reset_all_strobes", 512'(a_q.size()), 512'(0));

      // B: 5x5 ramp, K=3 stride 1
      for (int i = 0; i < 25; i++) step_b(1'b1, i);
      step_b(1'b0, 0);
      chk("b_strobe_count", 512'(b_n), 512'(9));
      lst = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
      for (int e = 0; e < 9; e++) b_ref[e*32 +: 32] = 32'(lst[e]);
      chk("b_last_window_literal", b_last_w, b_ref);

      // C: two channels, 3x3 frame, K=2 stride 1
      for (int i = 0; i < 9; i++) step_c(1'b1, i);
      step_c(1'b0, 0);
      chk("c_strobe_count", 512'(c_n), 512'(4));
      c_elem = c_last_w[63:48];
      chk("c_win11_elem11", c_elem, 16'h4808);
      c_elem = c_last_w[15:0];
      chk("c_win11_elem00", c_elem, 16'h4404);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
